// File: rtl/input_port_rc_pkg.sv
// Shared definitions for the router input port: flit fields, ids, ports, FSM states.
// Latency: n/a (constants and a pure combinational route helper).
// Backpressure: n/a.
package input_port_rc_pkg;

   // Flit id encodings (one-hot so a glance at a waveform tells the type)
   localparam logic [2:0] HEADER  = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL    = 3'b100;

   // Flit field bit positions
   localparam int ID_MSB  = 31;
   localparam int ID_LSB  = 29;
   localparam int LEN_MSB = 28;
   localparam int LEN_LSB = 17;
   localparam int DX_MSB  = 15;
   localparam int DX_LSB  = 12;
   localparam int DY_MSB  = 11;
   localparam int DY_LSB  = 8;

   // Output port indices within req[4:0] = {L,N,E,W,S}
   localparam int PORT_L = 4;
   localparam int PORT_N = 3;
   localparam int PORT_E = 2;
   localparam int PORT_W = 1;
   localparam int PORT_S = 0;

   // One-hot request encodings
   localparam logic [4:0] REQ_L = 5'b1 << PORT_L;
   localparam logic [4:0] REQ_N = 5'b1 << PORT_N;
   localparam logic [4:0] REQ_E = 5'b1 << PORT_E;
   localparam logic [4:0] REQ_W = 5'b1 << PORT_W;
   localparam logic [4:0] REQ_S = 5'b1 << PORT_S;

   // Route-compute FSM states
   typedef enum logic {
      IDLE_RC   = 1'b0,
      ACTIVE_RC = 1'b1
   } rc_state_e;

   // Dimension-ordered XY route: resolve X fully before Y, local when both match
   function automatic logic [4:0] xy_route(input logic [3:0] dst_x,
                                           input logic [3:0] dst_y,
                                           input logic [3:0] cur_x,
                                           input logic [3:0] cur_y);
      logic [4:0] r;
      if (dst_x > cur_x)      r = REQ_E;
      else if (dst_x < cur_x) r = REQ_W;
      else if (dst_y > cur_y) r = REQ_N;
      else if (dst_y < cur_y) r = REQ_S;
      else                    r = REQ_L;
      return r;
   endfunction

endpackage

// File: rtl/input_port_rc_flit_fifo.sv
// Synchronous flit buffer, power-of-two depth, no fall-through.
// Latency: a flit written at edge t is readable at the head after edge t.
// Backpressure: full_o/empty_o only; caller must gate push_i with !full_o and pop_i with !empty_o.
module flit_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] wr_dat_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] rd_dat_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;

   // Pointers advance on their own strobe and wrap naturally at the power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
      else if (!push_i && pop_i) count_d = count_q - CNT_ONE;
   end

   // Pointer/occupancy state; reset flushes the buffer without touching storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents are only meaningful below the occupancy count
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wr_dat_i;
   end

   assign rd_dat_o = mem_q[rd_ptr_q];
   assign full_o   = (count_q == CNT_MAX);
   assign empty_o  = (count_q == '0);

endmodule

// File: rtl/input_port_rc.sv
// Router input port: buffers flits, XY-routes each packet header, holds a one-hot request until TAIL pops.
// Latency: request rises one cycle after a header reaches the FIFO head; one bubble between packets.
// Backpressure: in_ready = !full (no same-cycle pop credit); head pops only on grant && out_valid.
module input_port_rc
   import input_port_rc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_flit,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_flit,
   output logic                  out_valid,
   output logic [2:0]            flit_id,
   output logic [11:0]           length,
   output logic [4:0]            req,
   input  logic                  grant,
   output logic                  err
);

   localparam logic [3:0] CX = 4'(CUR_X);
   localparam logic [3:0] CY = 4'(CUR_Y);

   rc_state_e             state_q, state_d;
   logic [4:0]            req_q, req_d;
   logic [11:0]           length_q, length_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] head;
   logic [2:0]            head_id;
   logic                  full, empty;
   logic                  push, pop, fwd_pop, drop;

   assign push    = in_valid && !full;
   assign head_id = head[ID_MSB:ID_LSB];

   flit_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .rst_ni   (rst),
      .push_i   (push),
      .wr_dat_i (in_flit),
      .pop_i    (pop),
      .rd_dat_o (head),
      .full_o   (full),
      .empty_o  (empty)
   );

   // State and latched route/length/error registers; reset drops req immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE_RC;
         req_q    <= '0;
         length_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         length_q <= length_d;
         err_q    <= err_d;
      end
   end

   // Next state: route headers in IDLE, drop strays there, release the route when TAIL pops
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      length_d = length_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE_RC: begin
            if (!empty) begin
               if (head_id == HEADER) begin
                  state_d  = ACTIVE_RC;
                  req_d    = xy_route(head[DX_MSB:DX_LSB], head[DY_MSB:DY_LSB], CX, CY);
                  length_d = head[LEN_MSB:LEN_LSB];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACTIVE_RC: begin
            if (fwd_pop && head_id == TAIL) begin
               state_d = IDLE_RC;
               req_d   = '0;
            end
         end
      endcase
   end

   // Outputs: head is only offered once routed; stray non-headers are discarded in IDLE
   always_comb begin
      out_valid = (state_q == ACTIVE_RC) && !empty;
      drop      = (state_q == IDLE_RC) && !empty && (head_id != HEADER);
      fwd_pop   = grant && out_valid;
      pop       = fwd_pop || drop;
      flit_id   = empty ? 3'b000 : head_id;
   end

   assign in_ready = !full;
   assign out_flit = head;
   assign length   = length_q;
   assign req      = req_q;
   assign err      = err_q;

endmodule

// File: tb/tb_input_port_rc.sv
module tb_input_port_rc;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CX    = 1;
   localparam int CY    = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_flit;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_flit;
   logic          out_valid;
   logic [2:0]    flit_id;
   logic [11:0]   length;
   logic [4:0]    req;
   logic          grant;
   logic          err;

   int checks = 0;
   int errors = 0;

   // Reference model: a plain flit queue plus "packet open" flag and latched route/length
   logic [DW-1:0] mq [$];
   bit            m_open;
   logic [4:0]    m_req;
   logic [11:0]   m_len;
   bit            m_err;

   always #5 clk = ~clk;

   input_port_rc #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .CUR_X      (CX),
      .CUR_Y      (CY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .flit_id   (flit_id),
      .length    (length),
      .req       (req),
      .grant     (grant),
      .err       (err)
   );

   function automatic logic [4:0] ref_route(input logic [3:0] dx, input logic [3:0] dy);
      int x = int'(dx);
      int y = int'(dy);
      if (x > CX) return 5'b00100;
      if (x < CX) return 5'b00010;
      if (y > CY) return 5'b01000;
      if (y < CY) return 5'b00001;
      return 5'b10000;
   endfunction

   function automatic logic [DW-1:0] mk_hdr(input logic [11:0] len, input logic [3:0] x, input logic [3:0] y);
      logic [DW-1:0] f;
      f = $urandom;
      f[31:29] = 3'b001;
      f[28:17] = len;
      f[15:12] = x;
      f[11:8]  = y;
      return f;
   endfunction

   function automatic logic [DW-1:0] mk_body(input logic [2:0] id);
      logic [DW-1:0] f;
      f = $urandom;
      f[31:29] = id;
      return f;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_open = 0;
      m_req  = '0;
      m_len  = '0;
      m_err  = 0;
   endtask

   // One clock: compare every output with the model at the falling edge, then advance the model
   task automatic tick();
      logic [DW-1:0] h;
      bit            e_rdy, e_vld, do_push, n_err;
      logic [2:0]    e_id;
      logic [DW-1:0] pf;
      @(negedge clk);
      e_rdy = (mq.size() < DEPTH);
      e_vld = m_open && (mq.size() > 0);
      e_id  = 3'b000;
      if (mq.size() > 0) begin
         h    = mq[0];
         e_id = h[31:29];
      end
      checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, e_rdy); end
      checks++; if (out_valid !== e_vld) begin errors++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, e_vld); end
      checks++; if (flit_id !== e_id) begin errors++; $display("FAIL flit_id t=%0t got=%b exp=%b", $time, flit_id, e_id); end
      checks++; if (req !== m_req) begin errors++; $display("FAIL req t=%0t got=%b exp=%b", $time, req, m_req); end
      checks++; if (length !== m_len) begin errors++; $display("FAIL length t=%0t got=%0d exp=%0d", $time, length, m_len); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL err t=%0t got=%b exp=%b", $time, err, m_err); end
      if (e_vld) begin
         checks++; if (out_flit !== h) begin errors++; $display("FAIL out_flit t=%0t got=%h exp=%h", $time, out_flit, h); end
      end
      do_push = in_valid && e_rdy;
      pf      = in_flit;
      n_err   = 0;
      if (mq.size() > 0) begin
         if (!m_open) begin
            if (h[31:29] == 3'b001) begin
               m_open = 1;
               m_req  = ref_route(h[15:12], h[11:8]);
               m_len  = h[28:17];
            end else begin
               void'(mq.pop_front());
               n_err = 1;
            end
         end else if (grant) begin
            void'(mq.pop_front());
            if (h[31:29] == 3'b100) begin
               m_open = 0;
               m_req  = '0;
            end
         end
      end
      if (do_push) mq.push_back(pf);
      m_err = n_err;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      in_valid = 1'b0;
      grant    = 1'b1;
      while ((mq.size() > 0 || m_open) && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (mq.size() > 0 || m_open) begin
         errors++;
         $display("FAIL drain_timeout got=%0d_left exp=0", mq.size());
      end
      grant = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; grant = 1'b0; in_flit = '0;
      model_reset();
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (req !== 5'b0) begin errors++; $display("FAIL reset_req got=%b exp=00000", req); end
      checks++; if (length !== 12'd0) begin errors++; $display("FAIL reset_length got=%0d exp=0", length); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_basic_east();
      grant = 1'b1;
      in_valid = 1'b1; in_flit = mk_hdr(12'd3, 4'd2, 4'd0);
      tick();
      in_flit = mk_body(3'b010);
      tick();
      checks++; if (req !== 5'b00100) begin errors++; $display("FAIL basic_req got=%b exp=00100", req); end
      checks++; if (length !== 12'd3) begin errors++; $display("FAIL basic_length got=%0d exp=3", length); end
      checks++; if (flit_id !== 3'b001) begin errors++; $display("FAIL basic_id_hdr got=%b exp=001", flit_id); end
      in_flit = mk_body(3'b100);
      tick();
      checks++; if (flit_id !== 3'b010) begin errors++; $display("FAIL basic_id_pay got=%b exp=010", flit_id); end
      in_valid = 1'b0;
      tick();
      checks++; if (flit_id !== 3'b100) begin errors++; $display("FAIL basic_id_tail got=%b exp=100", flit_id); end
      tick();
      checks++; if (req !== 5'b00000) begin errors++; $display("FAIL basic_req_release got=%b exp=00000", req); end
      drain(10);
   endtask

   task automatic test_routes();
      logic [3:0] dx [4] = '{4'd1, 4'd1, 4'd1, 4'd0};
      logic [3:0] dy [4] = '{4'd1, 4'd3, 4'd0, 4'd5};
      logic [4:0] ex [4] = '{5'b10000, 5'b01000, 5'b00001, 5'b00010};
      for (int i = 0; i < 4; i++) begin
         grant = 1'b0;
         in_valid = 1'b1; in_flit = mk_hdr(12'(i + 2), dx[i], dy[i]);
         tick();
         in_flit = mk_body(3'b100);
         tick();
         checks++; if (req !== ex[i]) begin errors++; $display("FAIL route_%0d got=%b exp=%b", i, req, ex[i]); end
         in_valid = 1'b0;
         drain(10);
      end
   endtask

   task automatic test_full();
      grant = 1'b0;
      in_valid = 1'b1;
      in_flit = mk_hdr(12'd5, 4'd3, 4'd3); tick();
      for (int i = 0; i < 3; i++) begin
         in_flit = mk_body(3'b010);
         tick();
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got=%b exp=0", in_ready); end
      in_flit = mk_body(3'b100);
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_5th_blocked got=%b exp=0", in_ready); end
      grant = 1'b1;
      tick();
      grant = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%b exp=1", in_ready); end
      tick();
      drain(20);
   endtask

   task automatic test_err_drop();
      int pulses = 0;
      grant = 1'b1;
      in_valid = 1'b1; in_flit = 32'h4000_0001;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (err === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL err_pulse_len got=%0d exp=1", pulses); end
      checks++; if (req !== 5'b0) begin errors++; $display("FAIL err_req_idle got=%b exp=00000", req); end
      in_valid = 1'b1; in_flit = mk_hdr(12'd2, 4'd1, 4'd9);
      tick();
      in_flit = mk_body(3'b100);
      tick();
      checks++; if (req !== 5'b01000) begin errors++; $display("FAIL err_next_route got=%b exp=01000", req); end
      drain(10);
   endtask

   task automatic test_gap();
      grant = 1'b1;
      in_valid = 1'b1; in_flit = mk_hdr(12'd3, 4'd0, 4'd0);
      tick();
      in_flit = mk_body(3'b010);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (req !== 5'b00010) begin errors++; $display("FAIL gap_req_%0d got=%b exp=00010", i, req); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid_%0d got=%b exp=0", i, out_valid); end
         checks++; if (flit_id !== 3'b000) begin errors++; $display("FAIL gap_id_%0d got=%b exp=000", i, flit_id); end
      end
      in_valid = 1'b1; in_flit = mk_body(3'b100);
      tick();
      drain(10);
   endtask

   task automatic test_async_reset();
      grant = 1'b0;
      in_valid = 1'b1; in_flit = mk_hdr(12'd4, 4'd5, 4'd1);
      tick();
      in_flit = mk_body(3'b010);
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (req !== 5'b0) begin errors++; $display("FAIL arst_req got=%b exp=00000", req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
      model_reset();
      @(posedge clk); #1;
      tick();
      #4 rst = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_flit = mk_hdr(12'd7, 4'd0, 4'd2);
      tick();
      in_flit = mk_body(3'b100);
      tick();
      checks++; if (req !== 5'b00010) begin errors++; $display("FAIL arst_reroute got=%b exp=00010", req); end
      checks++; if (length !== 12'd7) begin errors++; $display("FAIL arst_length got=%0d exp=7", length); end
      drain(10);
   endtask

   task automatic test_random();
      logic [DW-1:0] stream [$];
      bit            acc;
      for (int p = 0; p < 40; p++) begin
         int nb = $urandom_range(0, 3);
         stream.push_back(mk_hdr(12'($urandom_range(1, 4095)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
         for (int b = 0; b < nb; b++) stream.push_back(mk_body(($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010));
         stream.push_back(mk_body(3'b100));
         if ($urandom_range(0, 7) == 0) stream.push_back(mk_body(3'b010));
      end
      for (int c = 0; c < 4000 && stream.size() > 0; c++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_flit  = stream[0];
         grant    = ($urandom_range(0, 9) < 6);
         acc      = in_valid && (mq.size() < DEPTH);
         tick();
         if (acc) void'(stream.pop_front());
      end
      checks++;
      if (stream.size() != 0) begin errors++; $display("FAIL random_stall got=%0d_unsent exp=0", stream.size()); end
      drain(50);
   endtask

   initial begin
      test_reset();
      test_basic_east();
      test_routes();
      test_full();
      test_err_drop();
      test_gap();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/input_port_rc.md
Name: input_port_rc

Overview:
- Router input port that feeds the per-output arbiters.
- Buffers incoming flits in a small FIFO and decodes each HEADER flit.
- Computes the XY route for the packet and drives a one-hot request toward the selected output arbiter.
- Presents the flit id and packet length the arbiter timers need, and holds the route until the packet's TAIL flit is consumed.

Parameters:
- DATA_WIDTH, 32, flit width; bits [31:29] = flit_id, header bits [28:17] = length, [15:12] = dst_x, [11:8] = dst_y
- FIFO_DEPTH, 4, flit buffer entries (power of two, >= 2)
- CUR_X, 0, this router's X coordinate (4 bits)
- CUR_Y, 0, this router's Y coordinate (4 bits)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_flit  in  DATA_WIDTH  flit from upstream link
- in_valid  in  1  in_flit valid
- in_ready  out  1  buffer can accept; equals !full
- out_flit  out  DATA_WIDTH  FIFO head flit, to crossbar
- out_valid  out  1  head flit present and packet routed
- flit_id  out  3  head flit id when FIFO non-empty, else 3'b000; to arbiter timer
- length  out  12  length of current packet, latched at route time
- req  out  5  one-hot output request {L,N,E,W,S} = bits [4:0]
- grant  in  1  head flit consumed this cycle
- err  out  1  one-cycle pulse: non-HEADER flit dropped in IDLE

Behaviour:
- Reset values: FIFO empty, state IDLE, req=0, length=0, err=0, out_valid=0, in_ready=1.
- Push occurs when in_valid && in_ready.
- in_ready is low whenever the FIFO is full, even if a pop happens in the same cycle. This is deliberate and keeps the logic simple.
- Pop occurs when grant && out_valid. A grant while out_valid=0 is ignored.
- A simultaneous push and pop on a non-full FIFO is legal and leaves the count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- A flit pushed at cycle t is visible at the head at t+1 at the earliest. There is no fall-through.
- FSM states: IDLE, ACTIVE.
- IDLE, head flit is HEADER:
  - latch length = head[28:17];
  - latch the route;
  - go to ACTIVE next cycle; req is asserted from that cycle on.
  - Route latency is one cycle after the header reaches the head.
- IDLE, head flit is not HEADER: pop and drop it, pulse err for one cycle, stay in IDLE.
- IDLE, FIFO empty: hold IDLE.
- XY routing, evaluated in order:
  - dst_x > CUR_X: E
  - dst_x < CUR_X: W
  - dst_y > CUR_Y: N
  - dst_y < CUR_Y: S
  - otherwise: L
  - Comparisons are unsigned, 4 bits.
- ACTIVE:
  - req holds the latched one-hot value for the whole packet, including cycles where the FIFO runs empty mid-packet. This prevents the arbiter from releasing the grant early.
  - out_valid = !empty.
- ACTIVE, pop of a flit with id TAIL: return to IDLE next cycle and deassert req that same next cycle.
  - A following HEADER already at the head is routed in IDLE one cycle later, so there is a one-cycle bubble between packets.
- ACTIVE, HEADER at the head before a TAIL: forwarded as a normal flit with no re-route. Upstream guarantees well-formed packets.
- length holds its value in IDLE until the next header is latched.
- Asynchronous reset mid-packet: FIFO flushes, state returns to IDLE, req drops immediately. There is no recovery of a partial packet.
- Shared flit id encoding: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100. A single-flit packet is not supported.

Decomposition:
- Shared package/include holds:
  - flit id constants HEADER, PAYLOAD, TAIL;
  - flit field bit positions;
  - port index constants L=4, N=3, E=2, W=1, S=0;
  - the one-hot req encodings;
  - FSM state constants IDLE_RC, ACTIVE_RC.
- One sub-module: flit_fifo (parameterized DATA_WIDTH/FIFO_DEPTH synchronous FIFO with full, empty, and async active-low reset).
- Route compute and the FSM live in input_port_rc.

Test Plan:
- Reset, then push HEADER(len=3, dst=(2,0)) at CUR=(0,0), then PAYLOAD, then TAIL, with grant held at 1 -> req=5'b00100 (E) from 1 cycle after the header reaches the head; length=3; flit_id sequence 001, 010, 100; req=0 the cycle after TAIL pops.
- CUR=(1,1), headers to (1,1), (1,3), (1,0), (0,5) -> req = L (10000), N (01000), S (00001), W (00010) respectively; X is resolved before Y.
- grant=0, push 5 flits with FIFO_DEPTH=4 -> in_ready=0 after the 4th push; the 5th is not accepted; grant=1 for one cycle -> in_ready=1 the next cycle and no flit is lost or duplicated.
- IDLE, push PAYLOAD 32'h4000_0001 -> err pulses for exactly 1 cycle; flit dropped; req stays 0; the following header is routed normally.
- Mid-packet the FIFO runs empty for 3 cycles -> req stays asserted; out_valid=0; flit_id=000; a grant during the gap causes no pop.
- Assert rst low mid-packet, asynchronously between clock edges -> req=0, out_valid=0, in_ready=1 immediately; after release, a new header routes correctly.
